// File: rtl/store_seq_checker.sv
// Store-sequence checker: compares data-memory stores against a programmed table of
// expected (address, data) pairs, with an ignorable scratch address and a watchdog.
module store_seq_checker #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_EXPECTED   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          IGNORE_EN      = 1'b1,
  parameter logic [ADDR_WIDTH-1:0] IGNORE_ADDR = 96,
  localparam int unsigned IdxW = (NUM_EXPECTED > 1) ? $clog2(NUM_EXPECTED) : 1,
  localparam int unsigned CntW = $clog2(NUM_EXPECTED + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_write_i,
  input  logic [ADDR_WIDTH-1:0] data_address_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  exp_we_i,
  input  logic [IdxW-1:0]       exp_idx_i,
  input  logic [ADDR_WIDTH-1:0] exp_addr_i,
  input  logic [DATA_WIDTH-1:0] exp_data_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [CntW-1:0]       match_count_o,
  output logic [7:0]            ignore_count_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StRun, StPass, StFail, StTimeout} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       match_q, match_d;
  logic [7:0]            ign_q, ign_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

  logic [ADDR_WIDTH-1:0] tab_addr_q [NUM_EXPECTED];
  logic [DATA_WIDTH-1:0] tab_data_q [NUM_EXPECTED];

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  is_match, is_ignore;

  // Table is writable only while idle and survives restarts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_EXPECTED; i++) begin
        tab_addr_q[i] <= '0;
        tab_data_q[i] <= '0;
      end
    end else if (exp_we_i && state_q == StIdle) begin
      for (int unsigned i = 0; i < NUM_EXPECTED; i++) begin
        if (exp_idx_i == IdxW'(i)) begin
          tab_addr_q[i] <= exp_addr_i;
          tab_data_q[i] <= exp_data_i;
        end
      end
    end
  end

  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    for (int unsigned i = 0; i < NUM_EXPECTED; i++) begin
      if (match_q == CntW'(i)) begin
        cur_addr = tab_addr_q[i];
        cur_data = tab_data_q[i];
      end
    end
  end

  assign is_match  = mem_write_i && (data_address_i == cur_addr) && (write_data_i == cur_data);
  assign is_ignore = IGNORE_EN && (data_address_i == IGNORE_ADDR);

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    ign_d       = ign_q;
    wd_d        = wd_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    unique case (state_q)
      StIdle, StPass, StFail, StTimeout: begin
        if (start_i) begin
          state_d     = StRun;
          match_d     = '0;
          ign_d       = '0;
          wd_d        = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      StRun: begin
        if (is_match) begin
          match_d = match_q + 1'b1;
          wd_d    = '0;
          if (match_d == CntW'(NUM_EXPECTED)) state_d = StPass;
        end else if (mem_write_i && !is_ignore) begin
          state_d     = StFail;
          fail_addr_d = data_address_i;
          fail_data_d = write_data_i;
        end else begin
          if (mem_write_i && ign_q != 8'hFF) ign_d = ign_q + 8'd1;
          // Expiry is taken one edge after the count reaches the limit.
          if (wd_q == WdW'(TIMEOUT_CYCLES)) state_d = StTimeout;
          else                              wd_d    = wd_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      match_q     <= '0;
      ign_q       <= '0;
      wd_q        <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      ign_q       <= ign_d;
      wd_q        <= wd_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign busy_o         = (state_q == StRun);
  assign pass_o         = (state_q == StPass);
  assign fail_o         = (state_q == StFail);
  assign timeout_o      = (state_q == StTimeout);
  assign match_count_o  = match_q;
  assign ignore_count_o = ign_q;
  assign fail_addr_o    = fail_addr_q;
  assign fail_data_o    = fail_data_q;

endmodule

// File: doc/store_seq_checker.md
Name: store_seq_checker

Overview:
- Synthesisable store-sequence checker that watches the processor top's data-memory write port and compares each store against a programmed table of expected (address, data) pairs.
- Generalises the single-store pass/fail check to N ordered stores, a configurable ignorable scratch address, and a watchdog timeout.
- Sits beside the processor top, in simulation or on FPGA; status outputs can drive LEDs or a bench.

Parameters:
ADDR_WIDTH, 32, width of the monitored data address.
DATA_WIDTH, 32, width of the monitored write data.
NUM_EXPECTED, 2, number of entries in the expected store table (>=1).
TIMEOUT_CYCLES, 1024, max cycles in RUN without a matching store before TIMEOUT (>=2).
IGNORE_EN, 1, 1 enables silently skipping stores to IGNORE_ADDR.
IGNORE_ADDR, 96, scratch address whose non-matching stores are skipped.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous, active-low reset.
mem_write_i  in  1  store strobe from the processor top.
data_address_i  in  ADDR_WIDTH  store address.
write_data_i  in  DATA_WIDTH  store data.
exp_we_i  in  1  table write enable (honoured only in IDLE).
exp_idx_i  in  $clog2(NUM_EXPECTED) (min 1)  table entry index.
exp_addr_i  in  ADDR_WIDTH  expected address for the entry.
exp_data_i  in  DATA_WIDTH  expected data for the entry.
start_i  in  1  begin or restart checking.
busy_o  out  1  state == RUN.
pass_o  out  1  sticky: all entries matched in order.
fail_o  out  1  sticky: mismatching store seen.
timeout_o  out  1  sticky: watchdog expired.
match_count_o  out  $clog2(NUM_EXPECTED+1)  entries matched so far.
ignore_count_o  out  8  stores skipped; saturates at 255.
fail_addr_o  out  ADDR_WIDTH  address of the offending store.
fail_data_o  out  DATA_WIDTH  data of the offending store.

Behaviour:
- Reset (rst_ni low, async): state IDLE; every output 0; table entries cleared to 0; watchdog 0. A reset mid-RUN aborts the check immediately.
- States and transitions:
  - IDLE -> RUN on start_i.
  - RUN -> PASS / FAIL / TIMEOUT as below.
  - PASS / FAIL / TIMEOUT -> RUN on start_i.
  - No other transitions.
- Table:
  - In IDLE, exp_we_i writes entry exp_idx_i on the clock edge.
  - exp_we_i is ignored outside IDLE.
  - exp_idx_i >= NUM_EXPECTED is ignored.
  - The table is retained across restarts and cleared only by reset.
- start_i effect on entering RUN:
  - Clears match_count_o, ignore_count_o, fail_addr_o, fail_data_o, pass_o, fail_o, timeout_o and the watchdog.
  - Table is kept.
  - start_i while in RUN is ignored.
- RUN, on each edge with mem_write_i=1, compare against entry e = table[match_count] using full-width equality on both address and data:
  - Match:
    - match_count increments; watchdog resets.
    - If the new count == NUM_EXPECTED: -> PASS, pass_o=1.
  - Otherwise, if IGNORE_EN and data_address_i==IGNORE_ADDR:
    - ignore_count increments (saturating).
    - No state change; watchdog is not reset.
  - Otherwise: -> FAIL, fail_o=1, fail_addr_o and fail_data_o latch the store.
  - An exact match takes priority over ignore, so IGNORE_ADDR may itself appear in the table.
- Watchdog:
  - Counts every RUN cycle that has no matching store.
  - On reaching TIMEOUT_CYCLES, the next edge goes -> TIMEOUT with timeout_o=1.
  - A matching store on the expiry cycle wins (match, no timeout).
- Latency: all outputs are registered. Status changes are visible one cycle after the edge that samples the deciding store.
- Stores outside RUN are ignored and change no outputs.
- Exactly one of pass_o / fail_o / timeout_o is 1 in a terminal state; all three are 0 in IDLE and RUN.

Test Plan:
1. Table [0]=(84,7), [1]=(100,7); start; stores (96,3), (84,7), (96,5), (100,7) -> pass_o=1, match_count_o=2, ignore_count_o=2, busy_o=0 one cycle after the last store.
2. Same table; start; store (84,8) -> fail_o=1, fail_addr_o=84, fail_data_o=8, match_count_o=0; later stores change nothing.
3. TIMEOUT_CYCLES=16; start with no stores -> timeout_o=1 exactly 17 edges after start sampled. Repeat with a matching store on cycle 15 -> no timeout.
4. After store (84,7) in RUN, pull rst_ni low mid-cycle -> all outputs 0 immediately (async), table reads 0; a new start with stores (84,7), (100,7) -> fail_o=1, fail_addr_o=84 (entry 0 is (0,0)).
5. From PASS of scenario 1, pulse start_i and replay the same four stores -> all counts clear, then pass_o=1 again (table retained).
6. exp_we_i writing entry 0=(4,4) while in RUN -> table unchanged; store (200,1) while in IDLE -> no output change.
